instruction_feeder: RTL and testbench

- Initiator side of the processor's Run/Done/DIN handshake: holds a small program memory and issues instructions one at a time to processor_multiciclo.
- Drives DIN and Run, waits for Done, and supplies the immediate word for mvi.
- Sits between the testbench/board loader and the processor; replaces manual switch/key stimulus.

---
 rtl/instruction_feeder_if.sv | 29 ++
 rtl/instruction_feeder.sv | 190 +++++++++++++++++++
 tb/tb_instruction_feeder.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_feeder_if.sv
// Run/Done/DIN handshake plus program-load bus between the feeder and its environment.
interface instruction_feeder_if #(
   parameter int unsigned ADDR_W = 5
);
   logic              start;
   logic [ADDR_W:0]   prog_len;
   logic              load;
   logic [ADDR_W-1:0] load_addr;
   logic [15:0]       load_data;
   logic              done;
   logic [15:0]       din;
   logic              run;
   logic              busy;
   logic              finished;
   logic              error;
   logic [ADDR_W:0]   instr_count;

   // Feeder side: issues instructions, consumes loader controls and Done.
   modport master (
      input  start, prog_len, load, load_addr, load_data, done,
      output din, run, busy, finished, error, instr_count
   );

   // Environment side: loader/testbench plus the processor.
   modport slave (
      output start, prog_len, load, load_addr, load_data, done,
      input  din, run, busy, finished, error, instr_count
   );
endinterface

// File: rtl/instruction_feeder.sv
// Program memory plus sequencer that feeds instructions (and mvi immediates)
// to the multicycle processor over the Run/Done/DIN handshake.
module instruction_feeder #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned TIMEOUT = 15
) (
   input logic                  clock,
   input logic                  reset,
   instruction_feeder_if.master bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;
   localparam int unsigned TW    = $clog2(TIMEOUT + 1);
   localparam int unsigned DW    = 16;

   localparam logic [2:0] OP_MVI = 3'b001;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [DW-1:0]     mem [DEPTH];

   logic [1:0]        state,  state_nx;
   logic [PW-1:0]     pc,     pc_nx;
   logic [PW-1:0]     len_q,  len_nx;
   logic [PW-1:0]     cnt_q,  cnt_nx;
   logic [TW-1:0]     tmo_q,  tmo_nx;
   logic [DW-1:0]     din_q,  din_nx;
   logic              run_q,  run_nx;
   logic              busy_q, busy_nx;
   logic              fin_q,  fin_nx;
   logic              err_q,  err_nx;

   logic              wr_en;
   logic [PW-1:0]     la_pc;
   logic [PW-1:0]     la_len;
   logic [ADDR_W-1:0] la_addr;
   logic [DW-1:0]     la_word;
   logic              la_trunc;
   logic [PW-1:0]     pc_p1;
   logic [DW-1:0]     imm_word;
   logic              issue_mvi;
   logic              issue_trunc;

   // The loader owns the memory only while no program is running.
   assign wr_en = bus.load && !busy_q;

   // Program memory write port; contents deliberately survive reset.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[bus.load_addr] <= bus.load_data;
      end
   end

   // Look ahead at the word about to be issued so Run can be registered
   // in the same cycle the FSM sits in ISSUE. From IDLE the word is mem[0]
   // and the length is the one arriving with Start; a same-cycle load is
   // forwarded so "write first, then start" holds.
   assign la_pc    = (state == S_WAIT) ? pc    : '0;
   assign la_len   = (state == S_WAIT) ? len_q : bus.prog_len;
   assign la_addr  = la_pc[ADDR_W-1:0];
   assign la_word  = (wr_en && (bus.load_addr == la_addr)) ? bus.load_data : mem[la_addr];
   assign la_trunc = (la_word[8:6] == OP_MVI) && ((la_pc + PW'(1)) >= la_len);

   // Decode of the word currently presented on DIN during ISSUE.
   assign pc_p1       = pc + PW'(1);
   assign imm_word    = mem[pc_p1[ADDR_W-1:0]];
   assign issue_mvi   = (din_q[8:6] == OP_MVI);
   assign issue_trunc = issue_mvi && (pc_p1 >= len_q);

   // Next-state and next-output logic for the issue sequencer.
   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      len_nx   = len_q;
      cnt_nx   = cnt_q;
      tmo_nx   = tmo_q;
      din_nx   = din_q;
      run_nx   = 1'b0;
      busy_nx  = busy_q;
      fin_nx   = 1'b0;
      err_nx   = err_q;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               len_nx  = bus.prog_len;
               err_nx  = 1'b0;
               cnt_nx  = '0;
               pc_nx   = '0;
               busy_nx = 1'b1;
               if (bus.prog_len == '0) begin
                  state_nx = S_FINISH;
                  fin_nx   = 1'b1;
               end else begin
                  state_nx = S_ISSUE;
                  din_nx   = la_word;
                  run_nx   = !la_trunc;
               end
            end
         end

         S_ISSUE: begin
            if (issue_trunc) begin
               // mvi whose immediate lies beyond the program end
               err_nx   = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end else begin
               tmo_nx   = TW'(1);
               state_nx = S_WAIT;
               if (issue_mvi) begin
                  din_nx = imm_word;
                  pc_nx  = pc + PW'(2);
               end else begin
                  pc_nx  = pc_p1;
               end
            end
         end

         S_WAIT: begin
            if (bus.done) begin
               cnt_nx = cnt_q + PW'(1);
               if (pc >= len_q) begin
                  state_nx = S_FINISH;
                  fin_nx   = 1'b1;
               end else begin
                  state_nx = S_ISSUE;
                  din_nx   = la_word;
                  run_nx   = !la_trunc;
               end
            end else if (tmo_q == TW'(TIMEOUT)) begin
               err_nx   = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end else begin
               tmo_nx = tmo_q + TW'(1);
            end
         end

         S_FINISH: begin
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
         end

         default: begin
            state_nx = S_IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any run without a Finished pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         pc     <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
         tmo_q  <= '0;
         din_q  <= '0;
         run_q  <= 1'b0;
         busy_q <= 1'b0;
         fin_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         len_q  <= len_nx;
         cnt_q  <= cnt_nx;
         tmo_q  <= tmo_nx;
         din_q  <= din_nx;
         run_q  <= run_nx;
         busy_q <= busy_nx;
         fin_q  <= fin_nx;
         err_q  <= err_nx;
      end
   end

   assign bus.din         = din_q;
   assign bus.run         = run_q;
   assign bus.busy        = busy_q;
   assign bus.finished    = fin_q;
   assign bus.error       = err_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instruction_feeder.sv
// Directed bench for instruction_feeder: a processor stand-in answers Run with
// Done, a monitor records the issued DIN stream, and a program model predicts it.
module tb_instruction_feeder;

   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset;

   instruction_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   instruction_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ncmp  = 0;
   int nfail = 0;

   // main-block state
   logic [15:0] shadow [32];
   logic [15:0] exp_q [$];
   int          exp_ic;
   bit          exp_err;
   bit          exp_fin;
   int          cur_len;
   int          start_cyc = -100;
   int          obs_base, fin_base, viol_base;
   int          resp_dly = 1;
   bit          resp_en  = 1'b0;

   // monitor/responder state
   logic [15:0] obs_q [$];
   int          run_total    = 0;
   int          fin_total    = 0;
   int          viol         = 0;
   int          done_cyc     = -100;
   int          fin_cyc      = -100;
   int          err_rise_cyc = -100;
   int          resp_cnt     = 0;
   bit          imm_pending  = 1'b0;
   bit          prev_run     = 1'b0;
   bit          prev_err     = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Processor stand-in and output monitor, both on the falling edge.
   initial begin
      bus.done = 1'b0;
      forever begin
         @(negedge clk);
         bus.done = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               bus.done = 1'b1;
               done_cyc = cyc;
            end
         end
         if (imm_pending) obs_q.push_back(bus.din);
         imm_pending = 1'b0;
         if (bus.run === 1'b1) begin
            run_total++;
            obs_q.push_back(bus.din);
            if (bus.din[8:6] == 3'b001) imm_pending = 1'b1;
            if (prev_run) viol++;
            if (!((cyc == start_cyc + 1) || (cyc == done_cyc + 1))) viol++;
            if (resp_en) resp_cnt = resp_dly;
         end
         if (bus.finished === 1'b1) begin
            fin_total++;
            fin_cyc = cyc;
         end
         if ((bus.error === 1'b1) && !prev_err) err_rise_cyc = cyc;
         prev_run = (bus.run === 1'b1);
         prev_err = (bus.error === 1'b1);
      end
   end

   task automatic load_word(input int addr, input logic [15:0] data);
      @(negedge clk);
      bus.load      = 1'b1;
      bus.load_addr = 5'(addr);
      bus.load_data = data;
      shadow[addr]  = data;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   // Predict the DIN stream, then pulse Start (optionally with a same-cycle load).
   task automatic begin_run(input int len, input int dly, input bit en,
                            input bit with_load, input int la, input logic [15:0] ld);
      int          pc;
      logic [15:0] w;
      if (with_load) shadow[la] = ld;
      exp_q.delete();
      exp_ic  = 0;
      exp_err = 1'b0;
      pc      = 0;
      while (pc < len) begin
         w = shadow[pc];
         if (w[8:6] == 3'b001) begin
            if (pc + 1 >= len) begin
               exp_err = 1'b1;
               break;
            end
            exp_q.push_back(w);
            exp_q.push_back(shadow[pc+1]);
            pc += 2;
         end else begin
            exp_q.push_back(w);
            pc += 1;
         end
         exp_ic++;
      end
      exp_fin   = !exp_err;
      cur_len   = len;
      resp_dly  = dly;
      resp_en   = en;
      obs_base  = obs_q.size();
      fin_base  = fin_total;
      viol_base = viol;
      @(negedge clk);
      bus.prog_len = 6'(len);
      bus.start    = 1'b1;
      if (with_load) begin
         bus.load      = 1'b1;
         bus.load_addr = 5'(la);
         bus.load_data = ld;
      end
      start_cyc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      bus.load  = 1'b0;
      check("first_run", bus.run, (exp_q.size() > 0));
      check("busy_on", bus.busy, 1);
      check("err_clear", bus.error, 0);
   endtask

   // Wait for the run to end and compare everything it produced.
   task automatic end_run(input string name, input int budget);
      int n;
      for (int i = 0; i < budget && bus.busy; i++) @(negedge clk);
      check({name, ":busy_off"}, bus.busy, 0);
      check({name, ":error"}, bus.error, exp_err);
      check({name, ":instr_count"}, bus.instr_count, exp_ic);
      check({name, ":finished_cnt"}, fin_total - fin_base, exp_fin);
      check({name, ":run_spacing"}, viol - viol_base, 0);
      n = obs_q.size() - obs_base;
      check({name, ":stream_len"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check($sformatf("%s:word%0d", name, i), obs_q[obs_base+i], exp_q[i]);
      if (exp_fin)
         check({name, ":fin_time"}, fin_cyc, (cur_len == 0) ? start_cyc + 1 : done_cyc + 1);
   endtask

   task automatic run_program(input string name, input int len, input int dly);
      begin_run(len, dly, 1'b1, 1'b0, 0, 16'h0);
      end_run(name, 200);
   endtask

   initial begin
      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.prog_len  = '0;
      bus.load      = 1'b0;
      bus.load_addr = '0;
      bus.load_data = '0;
      repeat (2) @(negedge clk);
      check("rst:din", bus.din, 0);
      check("rst:run", bus.run, 0);
      check("rst:busy", bus.busy, 0);
      check("rst:finished", bus.finished, 0);
      check("rst:error", bus.error, 0);
      check("rst:instr_count", bus.instr_count, 0);
      reset = 1'b0;

      // single mv
      load_word(0, 16'h0001);
      run_program("mv", 1, 1);

      // mvi with immediate
      load_word(0, 16'h0050);
      load_word(1, 16'h0005);
      run_program("mvi", 2, 1);

      // multi-instruction program, slow Done
      load_word(2, 16'h0001);
      load_word(3, 16'h0081);
      load_word(4, 16'h00C1);
      run_program("multi", 5, 3);

      // timeout: Done never arrives
      load_word(0, 16'h0081);
      begin_run(1, 1, 1'b0, 1'b0, 0, 16'h0);
      exp_err = 1'b1;
      exp_ic  = 0;
      exp_fin = 1'b0;
      end_run("timeout", 60);
      check("timeout:err_time", err_rise_cyc, start_cyc + int'(TIMEOUT) + 2);

      // zero-length program; this Start also clears the timeout error
      run_program("len0", 0, 1);

      // truncated mvi
      load_word(0, 16'h0050);
      run_program("trunc", 1, 1);

      // Load and Start while Busy are both ignored
      begin_run(5, 3, 1'b1, 1'b0, 0, 16'h0);
      repeat (3) @(negedge clk);
      check("busy_mid", bus.busy, 1);
      bus.load      = 1'b1;
      bus.load_addr = 5'd2;
      bus.load_data = 16'hFFFF;
      bus.start     = 1'b1;
      bus.prog_len  = 6'd1;
      @(negedge clk);
      bus.load  = 1'b0;
      bus.start = 1'b0;
      end_run("busy_inject", 200);
      run_program("rerun", 5, 3);

      // Load and Start in the same cycle: new word is executed
      begin_run(1, 1, 1'b1, 1'b1, 0, 16'h00C1);
      end_run("load_start", 60);

      // reset while waiting for Done
      load_word(0, 16'h0050);
      begin_run(5, 1, 1'b0, 1'b0, 0, 16'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midrst:din", bus.din, 0);
      check("midrst:run", bus.run, 0);
      check("midrst:busy", bus.busy, 0);
      check("midrst:finished", bus.finished, 0);
      check("midrst:error", bus.error, 0);
      check("midrst:instr_count", bus.instr_count, 0);
      reset = 1'b0;
      @(negedge clk);
      check("midrst:no_finish", fin_total - fin_base, 0);
      run_program("after_reset", 5, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
